fir_fold_sequencer: RTL and testbench

//   Time-multiplexed controller for the 15-tap LPF: one shared signed multiplier-accumulator
//   is sequenced over all taps per input sample, replacing one multiplier per tap.

---
 rtl/fir_fold_sequencer_if.sv | 40 ++++
 rtl/fir_fold_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fir_fold_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_fold_sequencer_if.sv
// Stream and coefficient-port bundle for fir_fold_sequencer.
// The coefficient write signals exist only when FIR_COEF_LOAD_EN is defined.
// master: environment side (drives samples, accepts results).
// slave : the sequencer itself.
interface fir_fold_sequencer_if #(
  parameter int unsigned DWIDTH = 16
);
  logic [DWIDTH-1:0]   i_data;
  logic                i_valid;
  logic                o_ready;
  logic [2*DWIDTH-1:0] o_data;
  logic                o_valid;
  logic                i_ready;
  logic                o_busy;
`ifdef FIR_COEF_LOAD_EN
  logic                i_coef_we;
  logic [3:0]          i_coef_addr;
  logic [DWIDTH-1:0]   i_coef_data;

  modport master (
    output i_data, i_valid, i_ready, i_coef_we, i_coef_addr, i_coef_data,
    input  o_ready, o_data, o_valid, o_busy
  );

  modport slave (
    input  i_data, i_valid, i_ready, i_coef_we, i_coef_addr, i_coef_data,
    output o_ready, o_data, o_valid, o_busy
  );
`else
  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_busy
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_busy
  );
`endif
endinterface

// File: rtl/fir_fold_sequencer.sv
// Folded 15-tap low-pass FIR: a single signed MAC is sequenced over all taps of a
// circular delay line for each accepted sample.
// Optional feature macro: FIR_COEF_LOAD_EN (runtime coefficient write port, IDLE only).
// The multiplier output is registered, so one drain cycle follows the last tap;
// a sample accepted at edge E yields o_valid at edge E+NUM_TAPS+1.
module fir_fold_sequencer #(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned NUM_TAPS = 15
) (
  input logic                 clk,
  input logic                 rst,
  fir_fold_sequencer_if.slave bus
);

  localparam int unsigned PW      = 2 * DWIDTH;
  localparam logic [3:0]  LastTap = 4'(NUM_TAPS - 1);
  localparam logic [4:0]  NTaps   = 5'(NUM_TAPS);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  if (NUM_TAPS < 2 || NUM_TAPS > 16) begin : g_bad_taps
    $error("NUM_TAPS must be in 2..16");
  end

  // Low-pass tap set; symmetric about tap 7, taps 15 and up are zero.
  function automatic logic [DWIDTH-1:0] default_coef(input int idx);
    logic [15:0] c;
    case (idx)
      0, 14:   c = 16'hFC9C;
      2, 12:   c = 16'h05A5;
      4, 10:   c = 16'hF40C;
      6, 8:    c = 16'h282D;
      7:       c = 16'h4000;
      default: c = 16'h0000;
    endcase
    return DWIDTH'($signed(c));
  endfunction

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [PW-1:0]     data_q, data_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              prod_vld_q, prod_vld_d;
  logic              drain_q, drain_d;
  logic [3:0]        wp_q, wp_d;
  logic [3:0]        kcnt_q, kcnt_d;
  logic [DWIDTH-1:0] x_q [16];
  logic [DWIDTH-1:0] x_d [16];
  logic [DWIDTH-1:0] coef [16];

  logic              accept;
  logic [4:0]        idx_sum;
  logic [3:0]        rd_idx;
  logic signed [PW-1:0] product;

`ifdef FIR_COEF_LOAD_EN
  logic [DWIDTH-1:0] coef_q [16];
  logic [DWIDTH-1:0] coef_d [16];

  // Coefficient writes land only in IDLE and only for taps in use.
  always_comb begin
    coef_d = coef_q;
    if (state_q == StIdle && bus.i_coef_we && ({1'b0, bus.i_coef_addr} < NTaps)) begin
      coef_d[bus.i_coef_addr] = bus.i_coef_data;
    end
  end

  // Coefficient store, reset to the default tap set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) coef_q[i] <= default_coef(i);
    end else begin
      coef_q <= coef_d;
    end
  end

  // Expose the live store to the MAC.
  always_comb begin
    coef = coef_q;
  end
`else
  // Fixed coefficients.
  always_comb begin
    for (int i = 0; i < 16; i++) coef[i] = default_coef(i);
  end
`endif

  // Tap read address: (wp - kcnt) mod NUM_TAPS, kept in 5 bits to avoid underflow.
  always_comb begin
    idx_sum = {1'b0, wp_q} + NTaps - {1'b0, kcnt_q};
    rd_idx  = (idx_sum >= NTaps) ? 4'(idx_sum - NTaps) : idx_sum[3:0];
    product = $signed(coef[kcnt_q]) * $signed(x_q[rd_idx]);
  end

  // Sequencer next-state: accept, issue one tap per cycle, drain, then hold result.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    acc_d      = acc_q;
    prod_d     = prod_q;
    prod_vld_d = prod_vld_q;
    drain_d    = drain_q;
    wp_d       = wp_q;
    kcnt_d     = kcnt_q;
    x_d        = x_q;
    accept     = (state_q == StIdle) && ready_q && bus.i_valid;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d[wp_q]  = bus.i_data;
          acc_d      = '0;
          kcnt_d     = '0;
          prod_vld_d = 1'b0;
          drain_d    = 1'b0;
          state_d    = StMac;
        end
      end
      StMac: begin
        if (!drain_q) begin
          prod_d     = product;
          prod_vld_d = 1'b1;
          if (prod_vld_q) acc_d = acc_q + prod_q;
          if (kcnt_q == LastTap) begin
            drain_d = 1'b1;
          end else begin
            kcnt_d = kcnt_q + 4'd1;
          end
        end else begin
          // Fold in the last registered product and publish.
          acc_d      = acc_q + prod_q;
          data_d     = acc_q + prod_q;
          valid_d    = 1'b1;
          drain_d    = 1'b0;
          prod_vld_d = 1'b0;
          state_d    = StOut;
        end
      end
      StOut: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          wp_d    = (wp_q == LastTap) ? 4'd0 : wp_q + 4'd1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StIdle);
  end

  // State registers; reset clears any partial result and the delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      drain_q    <= 1'b0;
      wp_q       <= '0;
      kcnt_q     <= '0;
      for (int i = 0; i < 16; i++) x_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      acc_q      <= acc_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      drain_q    <= drain_d;
      wp_q       <= wp_d;
      kcnt_q     <= kcnt_d;
      x_q        <= x_d;
    end
  end

  // Output drive.
  always_comb begin
    bus.o_ready = ready_q;
    bus.o_valid = valid_q;
    bus.o_data  = data_q;
    bus.o_busy  = (state_q == StMac) || (state_q == StOut);
  end

endmodule

// File: tb/tb_fir_fold_sequencer.sv
// Bench for fir_fold_sequencer: reference is a direct convolution over the sample
// history since the last reset, y[n] = sum_k c[k] * x[n-k] modulo 2^32.
// Define FIR_COEF_LOAD_EN to include the coefficient-load scenario.
module tb_fir_fold_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned NT = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_fold_sequencer_if #(.DWIDTH(DW)) bus ();

  fir_fold_sequencer #(.DWIDTH(DW), .NUM_TAPS(NT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          mcoef [NT];
  int          hist [$];
  logic [31:0] imp_exp [NT];
  logic        timeout;
  int          lat;

  function automatic void model_reset();
    hist.delete();
    mcoef = '{-868, 0, 1445, 0, -3060, 0, 10285, 16384, 10285, 0, -3060, 0, 1445, 0, -868};
  endfunction

  function automatic logic [31:0] model_y();
    int s = 0;
    for (int k = 0; k < int'(NT); k++) begin
      if (k < hist.size()) s += mcoef[k] * hist[hist.size() - 1 - k];
    end
    return s;
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push(input logic [15:0] d);
    int n = 0;
    timeout = 1'b0;
    while (bus.o_ready !== 1'b1 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.o_ready !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    hist.push_back(int'($signed(d)));
  endtask

  task automatic wait_out(output int lat_o);
    lat_o   = 0;
    timeout = 1'b0;
    while (bus.o_valid !== 1'b1 && lat_o < 64) begin
      @(posedge clk);
      #1;
      lat_o++;
    end
    if (bus.o_valid !== 1'b1) timeout = 1'b1;
  endtask

  task automatic pop();
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.o_ready, bus.o_valid, bus.o_busy, bus.o_data} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b data=%h, want all 0",
               bus.o_ready, bus.o_valid, bus.o_busy, bus.o_data);
    end
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", bus.o_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_edge: got rdy=%b busy=%b vld=%b want 1 0 0",
               bus.o_ready, bus.o_busy, bus.o_valid);
    end
  endtask

  task automatic test_impulse(input string name);
    for (int i = 0; i < int'(NT); i++) begin
      push((i == 0) ? 16'h0001 : 16'h0000);
      wait_out(lat);
      checks++;
      if (timeout || bus.o_data !== imp_exp[i]) begin
        errors++;
        $display("FAIL %s out%0d: got %h want %h (timeout=%0b)",
                 name, i, bus.o_data, imp_exp[i], timeout);
      end
      pop();
    end
  endtask

  task automatic test_step();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push(16'h0001);
      wait_out(lat);
      checks++;
      if (timeout || lat != int'(NT) + 1) begin
        errors++;
        $display("FAIL step_latency%0d: got %0d edges want %0d", i, lat, NT + 1);
      end
      checks++;
      if (bus.o_data !== model_y()) begin
        errors++;
        $display("FAIL step_out%0d: got %h want %h", i, bus.o_data, model_y());
      end
      if (i >= 15) begin
        checks++;
        if (bus.o_data !== 32'h0000_7CF4) begin
          errors++;
          $display("FAIL step_full%0d: got %h want 00007cf4", i, bus.o_data);
        end
      end
      pop();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_y;
    do_reset();
    push(16'h0100);
    wait_out(lat);
    exp_y = model_y();
    for (int c = 0; c < 10; c++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 16'h7777;
      checks++;
      if (timeout || bus.o_valid !== 1'b1 || bus.o_data !== exp_y || bus.o_ready !== 1'b0 ||
          bus.o_busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got vld=%b data=%h rdy=%b busy=%b want 1 %h 0 1",
                 c, bus.o_valid, bus.o_data, bus.o_ready, bus.o_busy, exp_y);
      end
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    pop();
    push(16'h0002);
    wait_out(lat);
    checks++;
    if (timeout || bus.o_data !== model_y()) begin
      errors++;
      $display("FAIL backpressure_not_consumed: got %h want %h", bus.o_data, model_y());
    end
    pop();
  endtask

  task automatic test_reset_mid_mac();
    logic seen;
    do_reset();
    push(16'h1234);
    wait_out(lat);
    pop();
    push(16'h0001);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_ready, bus.o_valid, bus.o_busy, bus.o_data} !== 35'd0) begin
      errors++;
      $display("FAIL reset_mid_mac: got rdy=%b vld=%b busy=%b data=%h, want all 0",
               bus.o_ready, bus.o_valid, bus.o_busy, bus.o_data);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulse: got o_valid pulse=%b want 0", seen);
    end
    test_impulse("impulse_after_reset");
  endtask

  task automatic test_wrap_random();
    logic [15:0] d;
    logic [31:0] exp_y;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0:       d = 16'h8000;
        1:       d = 16'h7FFF;
        default: d = 16'($urandom());
      endcase
      push(d);
      wait_out(lat);
      exp_y = model_y();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
      checks++;
      if (timeout || bus.o_valid !== 1'b1 || bus.o_data !== exp_y) begin
        errors++;
        $display("FAIL wrap_random%0d: got vld=%b data=%h want 1 %h (in=%h)",
                 i, bus.o_valid, bus.o_data, exp_y, d);
      end
      pop();
    end
  endtask

`ifdef FIR_COEF_LOAD_EN
  task automatic test_coef_load();
    do_reset();
    @(posedge clk);
    #1;
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = 4'd7;
    bus.i_coef_data = 16'h7FFF;
    @(posedge clk);
    #1;
    bus.i_coef_addr = 4'd15;
    bus.i_coef_data = 16'h1234;
    @(posedge clk);
    #1;
    bus.i_coef_we = 1'b0;
    mcoef[7]      = 32'sd32767;
    imp_exp[7]    = 32'h0000_7FFF;
    for (int i = 0; i < int'(NT); i++) begin
      push((i == 0) ? 16'h0001 : 16'h0000);
      if (i == 0) begin
        // Write during MAC must be dropped.
        bus.i_coef_we   = 1'b1;
        bus.i_coef_addr = 4'd2;
        bus.i_coef_data = 16'h0777;
        @(posedge clk);
        #1;
        bus.i_coef_we = 1'b0;
      end
      wait_out(lat);
      checks++;
      if (timeout || bus.o_data !== imp_exp[i]) begin
        errors++;
        $display("FAIL coef_load_out%0d: got %h want %h", i, bus.o_data, imp_exp[i]);
      end
      pop();
    end
    // Write and accept in the same IDLE cycle: new coefficient applies.
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = 4'd0;
    bus.i_coef_data = 16'h0100;
    push(16'h0003);
    bus.i_coef_we = 1'b0;
    mcoef[0]      = 256;
    wait_out(lat);
    checks++;
    if (timeout || bus.o_data !== model_y()) begin
      errors++;
      $display("FAIL coef_write_with_accept: got %h want %h", bus.o_data, model_y());
    end
    pop();
    imp_exp[7] = 32'h0000_4000;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    imp_exp = '{32'hFFFF_FC9C, 32'h0, 32'h0000_05A5, 32'h0, 32'hFFFF_F40C, 32'h0,
                32'h0000_282D, 32'h0000_4000, 32'h0000_282D, 32'h0, 32'hFFFF_F40C, 32'h0,
                32'h0000_05A5, 32'h0, 32'hFFFF_FC9C};
`ifdef FIR_COEF_LOAD_EN
    bus.i_coef_we   = 1'b0;
    bus.i_coef_addr = '0;
    bus.i_coef_data = '0;
`endif
    model_reset();
    test_reset();
    test_impulse("impulse");
    test_step();
    test_backpressure();
    test_reset_mid_mac();
    test_wrap_random();
`ifdef FIR_COEF_LOAD_EN
    test_coef_load();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
